execute_stage: RTL and testbench
================================

Name: execute_stage

Overview:
- Execute stage of the RV32i five-stage pipeline. Sits directly downstream of the decode-to-execute pipeline register and consumes its *_E outputs.
- Performs operand forwarding, ALU operation, branch/jump resolution and PC redirect generation.
- Holds the execute-to-memory pipeline register, which drives the memory stage.
- Redirect is combinational in the same cycle; all *_M outputs are registered, giving 1-cycle latency.

Parameters:
- XLEN, 32, datapath width (fixed for RV32i)
- FLUSH_PC, 32'h2A2A_2A2A, debug pattern loaded into PC_Plus_4_M on flush

Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- Flush_M  in  1  synchronous bubble insert into the EX/MEM register
- REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E  in  1 each  control from ID/EX
- MEM_Control_E  in  3  funct3; load/store width for memory ops, branch condition for branches
- ALU_Control_E  in  4  ALU op
- Branch_Src_Sel_E  in  1  0: target base is PC_E; 1: target base is forwarded rs1 (JALR)
- ALU_SrcA_Sel_E  in  1  0: forwarded rs1; 1: PC_E
- ALU_SrcB_Sel_E  in  1  0: forwarded rs2; 1: Imm_Ext_E
- Result_Src_Sel_E  in  2  00 ALU, 01 memory, 10 PC+4
- RD_E  in  5  destination register
- REG_R_Data1_E, REG_R_Data2_E, Imm_Ext_E, PC_E, PC_Plus_4_E  in  32 each
- Fwd_A_Sel_E, Fwd_B_Sel_E  in  2 each  from hazard unit; 00 register data, 01 Result_W, 10 ALU_Result_M
- Result_W  in  32  writeback result
- PC_Src_E  out  1  redirect fetch (combinational)
- PC_Target_E  out  32  redirect address (combinational)
- REG_W_En_M, MEM_W_En_M  out  1 each
- MEM_Control_M  out  3
- Result_Src_Sel_M  out  2
- RD_M  out  5
- ALU_Result_M, MEM_W_Data_M, PC_Plus_4_M  out  32 each

Behaviour:
- Forwarding
  - FwdA and FwdB are selected per Fwd_*_Sel_E. Encoding 11 selects register data.
  - SrcA = ALU_SrcA_Sel_E ? PC_E : FwdA.
  - SrcB = ALU_SrcB_Sel_E ? Imm_Ext_E : FwdB.
- ALU ops
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLL, 0110 SRL, 0111 SRA; shift amount is SrcB[4:0].
  - 1000 SLT (signed), 1001 SLTU; result is zero-extended to 32 bits.
  - 1010 PASSB (LUI).
  - All other encodings produce 0.
  - Add/sub wraps modulo 2^32.
- Branch condition
  - Compares FwdA against FwdB, never SrcB.
  - Condition selected by MEM_Control_E: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU.
  - 010 and 011 are never taken.
- PC_Src_E = Jump_En_E | (Branch_En_E & cond).
- PC_Target_E
  - Branch_Src_Sel_E = 0: PC_E + Imm_Ext_E.
  - Branch_Src_Sel_E = 1: (FwdA + Imm_Ext_E) & ~32'h1.
  - Always driven, regardless of PC_Src_E.
- EX/MEM register, updated on posedge CLK with priority RST > Flush_M > load.
  - RST: every *_M output is cleared to 0.
  - Flush_M: REG_W_En_M = 0, MEM_W_En_M = 0, PC_Plus_4_M = FLUSH_PC; other *_M outputs hold.
  - Load: ALU_Result_M = ALU result, MEM_W_Data_M = FwdB, PC_Plus_4_M = PC_Plus_4_E; control and RD pass through.
- A bubble from ID/EX (all enables 0) yields PC_Src_E = 0 and no state change downstream.
- RST mid-stream discards the instruction in flight; the first post-reset cycle presents zeros on all *_M outputs.
- The block contains no stall input; the EX/MEM register loads every cycle unless RST or Flush_M is asserted.

Optional Feature:
- Macro: EXEC_PERF_CNT_EN.
- Defined:
  - Adds outputs Branch_Cnt and Taken_Cnt (32 bits each).
  - Branch_Cnt increments each cycle Branch_En_E = 1.
  - Taken_Cnt increments each cycle PC_Src_E = 1, including jumps.
  - Both counters wrap at 2^32 and clear on RST.
  - Both counters are frozen during the cycle Flush_M = 1.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- The shared definitions package holds:
  - an ALU op enum, 4 bits, values as above;
  - a branch-condition funct3 enum;
  - Result_Src and forwarding-select enums, 2 bits each;
  - the FLUSH_PC constant.
- One sub-module, alu: purely combinational, SrcA, SrcB, ALU_Control → result.
- Forwarding, branch compare, target generation and the EX/MEM register live in execute_stage.

Test Plan:
- ADD, SrcA = 5, SrcB = imm −3, no forwarding → next cycle ALU_Result_M = 2, REG_W_En_M = 1, RD_M copied from RD_E.
- Fwd_A_Sel_E = 10, ALU_Result_M = 0x10, REG_R_Data1_E = 0x99, SUB with rs2 = 1 → ALU_Result_M = 0xF. Repeat with Fwd_A_Sel_E = 01, Result_W = 7 → ALU_Result_M = 6.
- BLT, FwdA = 0xFFFF_FFFF (−1), FwdB = 1, PC_E = 0x100, Imm = 0x20 → PC_Src_E = 1, PC_Target_E = 0x120. BLTU with the same operands → PC_Src_E = 0.
- JALR, FwdA = 0x1001, Imm = 4, Branch_Src_Sel_E = 1, Result_Src_Sel_E = 10, PC_Plus_4_E = 0x48 → PC_Target_E = 0x1004, PC_Src_E = 1, next cycle PC_Plus_4_M = 0x48.
- Store with MEM_W_En_E = 1 and Flush_M = 1 in the same cycle → MEM_W_En_M = 0, REG_W_En_M = 0, PC_Plus_4_M = 0x2A2A_2A2A. RST asserted together with Flush_M → all *_M outputs = 0.
- SRA, SrcA = 0x8000_0000, SrcB = 0x24 (amount 4) → ALU_Result_M = 0xF800_0000. With EXEC_PERF_CNT_EN defined, 3 branches of which 1 is taken, plus 1 JAL → Branch_Cnt = 3, Taken_Cnt = 2.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// rtl/execute_stage_pkg.sv - shared enums and constants for the RV32i execute stage
package execute_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'b0000,
    ALU_SUB   = 4'b0001,
    ALU_AND   = 4'b0010,
    ALU_OR    = 4'b0011,
    ALU_XOR   = 4'b0100,
    ALU_SLL   = 4'b0101,
    ALU_SRL   = 4'b0110,
    ALU_SRA   = 4'b0111,
    ALU_SLT   = 4'b1000,
    ALU_SLTU  = 4'b1001,
    ALU_PASSB = 4'b1010
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_cond_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_e;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [31:0] FLUSH_PC = 32'h2A2A_2A2A;

endpackage

// File: rtl/execute_stage_if.sv
// rtl/execute_stage_if.sv - ID/EX, hazard and EX/MEM bundle for execute_stage; EXEC_PERF_CNT_EN adds counter outputs
interface execute_stage_if;
  logic        REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E;
  logic [2:0]  MEM_Control_E;
  logic [3:0]  ALU_Control_E;
  logic        Branch_Src_Sel_E, ALU_SrcA_Sel_E, ALU_SrcB_Sel_E;
  logic [1:0]  Result_Src_Sel_E;
  logic [4:0]  RD_E;
  logic [31:0] REG_R_Data1_E, REG_R_Data2_E, Imm_Ext_E, PC_E, PC_Plus_4_E;
  logic [1:0]  Fwd_A_Sel_E, Fwd_B_Sel_E;
  logic [31:0] Result_W;
  logic        Flush_M;
  logic        PC_Src_E;
  logic [31:0] PC_Target_E;
  logic        REG_W_En_M, MEM_W_En_M;
  logic [2:0]  MEM_Control_M;
  logic [1:0]  Result_Src_Sel_M;
  logic [4:0]  RD_M;
  logic [31:0] ALU_Result_M, MEM_W_Data_M, PC_Plus_4_M;
`ifdef EXEC_PERF_CNT_EN
  logic [31:0] Branch_Cnt, Taken_Cnt;
`endif

  modport master (
    output REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E, MEM_Control_E, ALU_Control_E,
           Branch_Src_Sel_E, ALU_SrcA_Sel_E, ALU_SrcB_Sel_E, Result_Src_Sel_E, RD_E,
           REG_R_Data1_E, REG_R_Data2_E, Imm_Ext_E, PC_E, PC_Plus_4_E,
           Fwd_A_Sel_E, Fwd_B_Sel_E, Result_W, Flush_M,
    input  PC_Src_E, PC_Target_E, REG_W_En_M, MEM_W_En_M, MEM_Control_M, Result_Src_Sel_M,
           RD_M, ALU_Result_M, MEM_W_Data_M, PC_Plus_4_M
`ifdef EXEC_PERF_CNT_EN
    , input Branch_Cnt, Taken_Cnt
`endif
  );

  modport slave (
    input  REG_W_En_E, MEM_W_En_E, Jump_En_E, Branch_En_E, MEM_Control_E, ALU_Control_E,
           Branch_Src_Sel_E, ALU_SrcA_Sel_E, ALU_SrcB_Sel_E, Result_Src_Sel_E, RD_E,
           REG_R_Data1_E, REG_R_Data2_E, Imm_Ext_E, PC_E, PC_Plus_4_E,
           Fwd_A_Sel_E, Fwd_B_Sel_E, Result_W, Flush_M,
    output PC_Src_E, PC_Target_E, REG_W_En_M, MEM_W_En_M, MEM_Control_M, Result_Src_Sel_M,
           RD_M, ALU_Result_M, MEM_W_Data_M, PC_Plus_4_M
`ifdef EXEC_PERF_CNT_EN
    , output Branch_Cnt, Taken_Cnt
`endif
  );
endinterface

// File: rtl/execute_stage_alu.sv
// rtl/execute_stage_alu.sv - combinational RV32i ALU
module execute_stage_alu (
  input  logic [3:0]  i_alu_control,
  input  logic [31:0] i_src_a,
  input  logic [31:0] i_src_b,
  output logic [31:0] o_result
);
  import execute_stage_pkg::*;

  logic [4:0] w_shamt;
  assign w_shamt = i_src_b[4:0];

  // Select the result for the requested op; unknown encodings give zero
  always_comb begin
    o_result = '0;
    case (alu_op_e'(i_alu_control))
      ALU_ADD:   o_result = i_src_a + i_src_b;
      ALU_SUB:   o_result = i_src_a - i_src_b;
      ALU_AND:   o_result = i_src_a & i_src_b;
      ALU_OR:    o_result = i_src_a | i_src_b;
      ALU_XOR:   o_result = i_src_a ^ i_src_b;
      ALU_SLL:   o_result = i_src_a << w_shamt;
      ALU_SRL:   o_result = i_src_a >> w_shamt;
      ALU_SRA:   o_result = $unsigned($signed(i_src_a) >>> w_shamt);
      ALU_SLT:   o_result = {31'b0, $signed(i_src_a) < $signed(i_src_b)};
      ALU_SLTU:  o_result = {31'b0, i_src_a < i_src_b};
      ALU_PASSB: o_result = i_src_b;
      default:   o_result = '0;
    endcase
  end
endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - RV32i execute stage: forwarding, ALU, branch resolve, EX/MEM register; EXEC_PERF_CNT_EN adds branch counters
module execute_stage #(
  parameter int          XLEN     = 32,
  parameter logic [31:0] FLUSH_PC = execute_stage_pkg::FLUSH_PC
) (
  input  logic            CLK,
  input  logic            RST,
  execute_stage_if.slave  ex_if
);
  import execute_stage_pkg::*;

  logic [XLEN-1:0] w_fwd_a, w_fwd_b, w_src_a, w_src_b, w_alu_result;
  logic [XLEN-1:0] w_target_base, w_target_sum;
  logic            w_eq, w_lt, w_ltu, w_cond, w_pc_src;

  logic            r_reg_w_en_m, r_mem_w_en_m;
  logic [2:0]      r_mem_control_m;
  logic [1:0]      r_result_src_sel_m;
  logic [4:0]      r_rd_m;
  logic [XLEN-1:0] r_alu_result_m, r_mem_w_data_m, r_pc_plus_4_m;

  // Operand forwarding from writeback or from this stage's own EX/MEM result
  always_comb begin
    w_fwd_a = ex_if.REG_R_Data1_E;
    w_fwd_b = ex_if.REG_R_Data2_E;
    case (fwd_sel_e'(ex_if.Fwd_A_Sel_E))
      FWD_WB:  w_fwd_a = ex_if.Result_W;
      FWD_MEM: w_fwd_a = r_alu_result_m;
      default: w_fwd_a = ex_if.REG_R_Data1_E;
    endcase
    case (fwd_sel_e'(ex_if.Fwd_B_Sel_E))
      FWD_WB:  w_fwd_b = ex_if.Result_W;
      FWD_MEM: w_fwd_b = r_alu_result_m;
      default: w_fwd_b = ex_if.REG_R_Data2_E;
    endcase
  end

  assign w_src_a = ex_if.ALU_SrcA_Sel_E ? ex_if.PC_E : w_fwd_a;
  assign w_src_b = ex_if.ALU_SrcB_Sel_E ? ex_if.Imm_Ext_E : w_fwd_b;

  execute_stage_alu u_alu (
    .i_alu_control (ex_if.ALU_Control_E),
    .i_src_a       (w_src_a),
    .i_src_b       (w_src_b),
    .o_result      (w_alu_result)
  );

  // Branch compare always uses the forwarded registers, never the immediate
  assign w_eq  = (w_fwd_a == w_fwd_b);
  assign w_lt  = ($signed(w_fwd_a) < $signed(w_fwd_b));
  assign w_ltu = (w_fwd_a < w_fwd_b);

  // Decode funct3 into the taken condition; 010/011 never take
  always_comb begin
    w_cond = 1'b0;
    case (br_cond_e'(ex_if.MEM_Control_E))
      BR_EQ:   w_cond = w_eq;
      BR_NE:   w_cond = ~w_eq;
      BR_LT:   w_cond = w_lt;
      BR_GE:   w_cond = ~w_lt;
      BR_LTU:  w_cond = w_ltu;
      BR_GEU:  w_cond = ~w_ltu;
      default: w_cond = 1'b0;
    endcase
  end

  assign w_pc_src      = ex_if.Jump_En_E | (ex_if.Branch_En_E & w_cond);
  assign w_target_base = ex_if.Branch_Src_Sel_E ? w_fwd_a : ex_if.PC_E;
  assign w_target_sum  = w_target_base + ex_if.Imm_Ext_E;

  assign ex_if.PC_Src_E    = w_pc_src;
  assign ex_if.PC_Target_E = ex_if.Branch_Src_Sel_E ? {w_target_sum[XLEN-1:1], 1'b0} : w_target_sum;

  // EX/MEM register: reset clears, flush kills side effects and tags PC+4, otherwise load
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_reg_w_en_m       <= 1'b0;
      r_mem_w_en_m       <= 1'b0;
      r_mem_control_m    <= '0;
      r_result_src_sel_m <= '0;
      r_rd_m             <= '0;
      r_alu_result_m     <= '0;
      r_mem_w_data_m     <= '0;
      r_pc_plus_4_m      <= '0;
    end else if (ex_if.Flush_M) begin
      r_reg_w_en_m  <= 1'b0;
      r_mem_w_en_m  <= 1'b0;
      r_pc_plus_4_m <= FLUSH_PC;
    end else begin
      r_reg_w_en_m       <= ex_if.REG_W_En_E;
      r_mem_w_en_m       <= ex_if.MEM_W_En_E;
      r_mem_control_m    <= ex_if.MEM_Control_E;
      r_result_src_sel_m <= ex_if.Result_Src_Sel_E;
      r_rd_m             <= ex_if.RD_E;
      r_alu_result_m     <= w_alu_result;
      r_mem_w_data_m     <= w_fwd_b;
      r_pc_plus_4_m      <= ex_if.PC_Plus_4_E;
    end
  end

  assign ex_if.REG_W_En_M       = r_reg_w_en_m;
  assign ex_if.MEM_W_En_M       = r_mem_w_en_m;
  assign ex_if.MEM_Control_M    = r_mem_control_m;
  assign ex_if.Result_Src_Sel_M = r_result_src_sel_m;
  assign ex_if.RD_M             = r_rd_m;
  assign ex_if.ALU_Result_M     = r_alu_result_m;
  assign ex_if.MEM_W_Data_M     = r_mem_w_data_m;
  assign ex_if.PC_Plus_4_M      = r_pc_plus_4_m;

`ifdef EXEC_PERF_CNT_EN
  logic [31:0] r_branch_cnt, r_taken_cnt;

  // Branch and redirect counters, frozen while the EX/MEM register is flushed
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_branch_cnt <= '0;
      r_taken_cnt  <= '0;
    end else if (!ex_if.Flush_M) begin
      if (ex_if.Branch_En_E) r_branch_cnt <= r_branch_cnt + 32'd1;
      if (w_pc_src)          r_taken_cnt  <= r_taken_cnt + 32'd1;
    end
  end

  assign ex_if.Branch_Cnt = r_branch_cnt;
  assign ex_if.Taken_Cnt  = r_taken_cnt;
`endif
endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage with a behavioural reference model
module tb_execute_stage;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  execute_stage_if ex_if();
  execute_stage u_dut (.CLK(CLK), .RST(RST), .ex_if(ex_if));

  int checks = 0;
  int errors = 0;

  logic        m_reg_w, m_mem_w;
  logic [2:0]  m_ctl;
  logic [1:0]  m_res;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wdata, m_pc4;
  logic [31:0] m_bcnt, m_tcnt;
  logic        exp_src;
  logic [31:0] exp_target;

  function automatic logic [31:0] pick_fwd(input logic [1:0] sel, input logic [31:0] rd, wb, mem);
    logic [31:0] opts [4];
    opts[0] = rd; opts[1] = wb; opts[2] = mem; opts[3] = rd;
    return opts[sel];
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    int unsigned sh;
    logic [31:0] ones;
    sh = b % 32;
    ones = 32'hFFFF_FFFF;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a - b;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return a << sh;
      4'd6:  return a >> sh;
      4'd7:  return (a >> sh) | (a[31] ? ~(ones >> sh) : 32'd0);
      4'd8:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
      4'd9:  return (a < b) ? 32'd1 : 32'd0;
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_taken(input logic [2:0] f3, input logic [31:0] a, b);
    logic hit;
    case (f3[2:1])
      2'b00:   hit = (a == b);
      2'b10:   hit = (int'(a) < int'(b));
      2'b11:   hit = (a < b);
      default: return 1'b0;
    endcase
    return hit ^ f3[0];
  endfunction

  task automatic calc_comb();
    logic [31:0] fa, fb;
    fa = pick_fwd(ex_if.Fwd_A_Sel_E, ex_if.REG_R_Data1_E, ex_if.Result_W, m_alu);
    fb = pick_fwd(ex_if.Fwd_B_Sel_E, ex_if.REG_R_Data2_E, ex_if.Result_W, m_alu);
    exp_src = ex_if.Jump_En_E | (ex_if.Branch_En_E & ref_taken(ex_if.MEM_Control_E, fa, fb));
    if (ex_if.Branch_Src_Sel_E) exp_target = (fa + ex_if.Imm_Ext_E) & ~32'h1;
    else                        exp_target = ex_if.PC_E + ex_if.Imm_Ext_E;
  endtask

  task automatic tick();
    logic [31:0] fa, fb, res;
    calc_comb();
    fa  = pick_fwd(ex_if.Fwd_A_Sel_E, ex_if.REG_R_Data1_E, ex_if.Result_W, m_alu);
    fb  = pick_fwd(ex_if.Fwd_B_Sel_E, ex_if.REG_R_Data2_E, ex_if.Result_W, m_alu);
    res = ref_alu(ex_if.ALU_Control_E, ex_if.ALU_SrcA_Sel_E ? ex_if.PC_E : fa,
                  ex_if.ALU_SrcB_Sel_E ? ex_if.Imm_Ext_E : fb);
    @(posedge CLK);
    #1;
    if (RST) begin
      {m_reg_w, m_mem_w, m_ctl, m_res, m_rd, m_alu, m_wdata, m_pc4} = '0;
      m_bcnt = 0; m_tcnt = 0;
    end else if (ex_if.Flush_M) begin
      m_reg_w = 0; m_mem_w = 0; m_pc4 = 32'h2A2A_2A2A;
    end else begin
      m_reg_w = ex_if.REG_W_En_E; m_mem_w = ex_if.MEM_W_En_E; m_ctl = ex_if.MEM_Control_E;
      m_res = ex_if.Result_Src_Sel_E; m_rd = ex_if.RD_E; m_alu = res; m_wdata = fb;
      m_pc4 = ex_if.PC_Plus_4_E;
    end
    if (!RST && !ex_if.Flush_M) begin
      m_bcnt = m_bcnt + 32'(ex_if.Branch_En_E);
      m_tcnt = m_tcnt + 32'(exp_src);
    end
  endtask

  task automatic clear_inputs();
    ex_if.REG_W_En_E = 0; ex_if.MEM_W_En_E = 0; ex_if.Jump_En_E = 0; ex_if.Branch_En_E = 0;
    ex_if.MEM_Control_E = 0; ex_if.ALU_Control_E = 0; ex_if.Branch_Src_Sel_E = 0;
    ex_if.ALU_SrcA_Sel_E = 0; ex_if.ALU_SrcB_Sel_E = 0; ex_if.Result_Src_Sel_E = 0;
    ex_if.RD_E = 0; ex_if.REG_R_Data1_E = 0; ex_if.REG_R_Data2_E = 0; ex_if.Imm_Ext_E = 0;
    ex_if.PC_E = 0; ex_if.PC_Plus_4_E = 0; ex_if.Fwd_A_Sel_E = 0; ex_if.Fwd_B_Sel_E = 0;
    ex_if.Result_W = 0; ex_if.Flush_M = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1;
    ex_if.REG_W_En_E = 1; ex_if.MEM_W_En_E = 1; ex_if.RD_E = 5'd3; ex_if.PC_Plus_4_E = 32'h44;
    tick();
    tick();
    checks++;
    if ({ex_if.REG_W_En_M, ex_if.MEM_W_En_M, ex_if.MEM_Control_M, ex_if.Result_Src_Sel_M, ex_if.RD_M,
         ex_if.ALU_Result_M, ex_if.MEM_W_Data_M, ex_if.PC_Plus_4_M} !== 108'd0) begin
      errors++; $display("FAIL reset_m_outputs: got pc4=%h rd=%h, required all zero", ex_if.PC_Plus_4_M, ex_if.RD_M);
    end
`ifdef EXEC_PERF_CNT_EN
    checks++;
    if ({ex_if.Branch_Cnt, ex_if.Taken_Cnt} !== 64'd0) begin
      errors++; $display("FAIL reset_counters: got %h/%h, required 0/0", ex_if.Branch_Cnt, ex_if.Taken_Cnt);
    end
`endif
    RST = 0;
  endtask

  task automatic test_add();
    clear_inputs();
    ex_if.REG_W_En_E = 1; ex_if.REG_R_Data1_E = 32'd5; ex_if.Imm_Ext_E = 32'hFFFF_FFFD;
    ex_if.ALU_SrcB_Sel_E = 1; ex_if.ALU_Control_E = 4'b0000; ex_if.RD_E = 5'd7;
    tick();
    checks++;
    if (ex_if.ALU_Result_M !== 32'd2) begin
      errors++; $display("FAIL add_result: got %h, required 00000002", ex_if.ALU_Result_M);
    end
    checks++;
    if (ex_if.REG_W_En_M !== 1'b1 || ex_if.RD_M !== 5'd7) begin
      errors++; $display("FAIL add_ctrl: got wen=%b rd=%0d, required wen=1 rd=7", ex_if.REG_W_En_M, ex_if.RD_M);
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    ex_if.REG_W_En_E = 1; ex_if.REG_R_Data1_E = 32'h10; ex_if.ALU_SrcB_Sel_E = 1;
    tick();
    ex_if.ALU_SrcB_Sel_E = 0; ex_if.ALU_Control_E = 4'b0001; ex_if.Fwd_A_Sel_E = 2'b10;
    ex_if.REG_R_Data1_E = 32'h99; ex_if.REG_R_Data2_E = 32'd1;
    tick();
    checks++;
    if (ex_if.ALU_Result_M !== 32'hF) begin
      errors++; $display("FAIL fwd_mem: got %h, required 0000000f", ex_if.ALU_Result_M);
    end
    checks++;
    if (ex_if.MEM_W_Data_M !== 32'd1) begin
      errors++; $display("FAIL fwd_wdata: got %h, required 00000001", ex_if.MEM_W_Data_M);
    end
    ex_if.Fwd_A_Sel_E = 2'b01; ex_if.Result_W = 32'd7;
    tick();
    checks++;
    if (ex_if.ALU_Result_M !== 32'd6) begin
      errors++; $display("FAIL fwd_wb: got %h, required 00000006", ex_if.ALU_Result_M);
    end
  endtask

  task automatic test_branch();
    clear_inputs();
    ex_if.Branch_En_E = 1; ex_if.MEM_Control_E = 3'b100; ex_if.REG_R_Data1_E = 32'hFFFF_FFFF;
    ex_if.REG_R_Data2_E = 32'd1; ex_if.PC_E = 32'h100; ex_if.Imm_Ext_E = 32'h20;
    #1;
    checks++;
    if (ex_if.PC_Src_E !== 1'b1 || ex_if.PC_Target_E !== 32'h120) begin
      errors++; $display("FAIL blt: got src=%b tgt=%h, required src=1 tgt=00000120", ex_if.PC_Src_E, ex_if.PC_Target_E);
    end
    ex_if.MEM_Control_E = 3'b110;
    #1;
    checks++;
    if (ex_if.PC_Src_E !== 1'b0 || ex_if.PC_Target_E !== 32'h120) begin
      errors++; $display("FAIL bltu: got src=%b tgt=%h, required src=0 tgt=00000120", ex_if.PC_Src_E, ex_if.PC_Target_E);
    end
    ex_if.MEM_Control_E = 3'b011; ex_if.REG_R_Data2_E = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (ex_if.PC_Src_E !== 1'b0) begin
      errors++; $display("FAIL br_reserved: got src=%b, required 0", ex_if.PC_Src_E);
    end
    ex_if.Branch_En_E = 0; ex_if.MEM_Control_E = 3'b000;
    #1;
    checks++;
    if (ex_if.PC_Src_E !== 1'b0) begin
      errors++; $display("FAIL bubble: got src=%b, required 0", ex_if.PC_Src_E);
    end
    tick();
  endtask

  task automatic test_jalr();
    clear_inputs();
    ex_if.Jump_En_E = 1; ex_if.REG_W_En_E = 1; ex_if.Branch_Src_Sel_E = 1; ex_if.Result_Src_Sel_E = 2'b10;
    ex_if.REG_R_Data1_E = 32'h1001; ex_if.Imm_Ext_E = 32'd4; ex_if.PC_Plus_4_E = 32'h48; ex_if.PC_E = 32'h44;
    #1;
    checks++;
    if (ex_if.PC_Src_E !== 1'b1 || ex_if.PC_Target_E !== 32'h1004) begin
      errors++; $display("FAIL jalr_target: got src=%b tgt=%h, required src=1 tgt=00001004", ex_if.PC_Src_E, ex_if.PC_Target_E);
    end
    tick();
    checks++;
    if (ex_if.PC_Plus_4_M !== 32'h48 || ex_if.Result_Src_Sel_M !== 2'b10) begin
      errors++; $display("FAIL jalr_link: got pc4=%h rsel=%b, required pc4=00000048 rsel=10", ex_if.PC_Plus_4_M, ex_if.Result_Src_Sel_M);
    end
  endtask

  task automatic test_flush();
    clear_inputs();
    ex_if.REG_W_En_E = 1; ex_if.RD_E = 5'd9; ex_if.REG_R_Data1_E = 32'd3;
    tick();
    ex_if.REG_W_En_E = 0; ex_if.MEM_W_En_E = 1; ex_if.RD_E = 5'd31; ex_if.REG_R_Data1_E = 32'h55;
    ex_if.Flush_M = 1;
    tick();
    checks++;
    if (ex_if.MEM_W_En_M !== 1'b0 || ex_if.REG_W_En_M !== 1'b0 || ex_if.PC_Plus_4_M !== 32'h2A2A_2A2A) begin
      errors++; $display("FAIL flush_kill: got mwen=%b wen=%b pc4=%h, required 0 0 2a2a2a2a",
                         ex_if.MEM_W_En_M, ex_if.REG_W_En_M, ex_if.PC_Plus_4_M);
    end
    checks++;
    if (ex_if.RD_M !== 5'd9 || ex_if.ALU_Result_M !== 32'd3) begin
      errors++; $display("FAIL flush_hold: got rd=%0d alu=%h, required rd=9 alu=00000003", ex_if.RD_M, ex_if.ALU_Result_M);
    end
    RST = 1;
    tick();
    checks++;
    if ({ex_if.REG_W_En_M, ex_if.MEM_W_En_M, ex_if.MEM_Control_M, ex_if.Result_Src_Sel_M, ex_if.RD_M,
         ex_if.ALU_Result_M, ex_if.MEM_W_Data_M, ex_if.PC_Plus_4_M} !== 108'd0) begin
      errors++; $display("FAIL rst_over_flush: got pc4=%h rd=%0d, required all zero", ex_if.PC_Plus_4_M, ex_if.RD_M);
    end
    RST = 0; ex_if.Flush_M = 0;
  endtask

  task automatic test_sra();
    clear_inputs();
    ex_if.ALU_Control_E = 4'b0111; ex_if.REG_R_Data1_E = 32'h8000_0000; ex_if.Imm_Ext_E = 32'h24;
    ex_if.ALU_SrcB_Sel_E = 1;
    tick();
    checks++;
    if (ex_if.ALU_Result_M !== 32'hF800_0000) begin
      errors++; $display("FAIL sra: got %h, required f8000000", ex_if.ALU_Result_M);
    end
  endtask

`ifdef EXEC_PERF_CNT_EN
  task automatic test_perf();
    clear_inputs();
    RST = 1; tick(); RST = 0;
    ex_if.Branch_En_E = 1; ex_if.REG_R_Data1_E = 32'd5; ex_if.REG_R_Data2_E = 32'd5;
    ex_if.MEM_Control_E = 3'b000; tick();
    ex_if.MEM_Control_E = 3'b001; tick();
    ex_if.REG_R_Data2_E = 32'd3; ex_if.MEM_Control_E = 3'b100; tick();
    ex_if.Branch_En_E = 0; ex_if.Jump_En_E = 1; tick();
    ex_if.Jump_En_E = 0;
    checks++;
    if (ex_if.Branch_Cnt !== 32'd3 || ex_if.Taken_Cnt !== 32'd2) begin
      errors++; $display("FAIL perf_counts: got %0d/%0d, required 3/2", ex_if.Branch_Cnt, ex_if.Taken_Cnt);
    end
    ex_if.Branch_En_E = 1; ex_if.Jump_En_E = 1; ex_if.Flush_M = 1; tick();
    clear_inputs();
    checks++;
    if (ex_if.Branch_Cnt !== 32'd3 || ex_if.Taken_Cnt !== 32'd2) begin
      errors++; $display("FAIL perf_frozen: got %0d/%0d, required 3/2", ex_if.Branch_Cnt, ex_if.Taken_Cnt);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      RST = ($urandom_range(0, 39) == 0);
      ex_if.Flush_M = ($urandom_range(0, 7) == 0);
      ex_if.REG_W_En_E = 1'($urandom); ex_if.MEM_W_En_E = 1'($urandom);
      ex_if.Jump_En_E = ($urandom_range(0, 5) == 0); ex_if.Branch_En_E = 1'($urandom);
      ex_if.MEM_Control_E = 3'($urandom); ex_if.ALU_Control_E = 4'($urandom);
      ex_if.Branch_Src_Sel_E = 1'($urandom); ex_if.ALU_SrcA_Sel_E = 1'($urandom);
      ex_if.ALU_SrcB_Sel_E = 1'($urandom); ex_if.Result_Src_Sel_E = 2'($urandom);
      ex_if.RD_E = 5'($urandom); ex_if.REG_R_Data1_E = $urandom;
      ex_if.REG_R_Data2_E = ($urandom_range(0, 3) == 0) ? ex_if.REG_R_Data1_E : $urandom;
      ex_if.Imm_Ext_E = $urandom; ex_if.PC_E = $urandom; ex_if.PC_Plus_4_E = ex_if.PC_E + 32'd4;
      ex_if.Fwd_A_Sel_E = 2'($urandom); ex_if.Fwd_B_Sel_E = 2'($urandom); ex_if.Result_W = $urandom;
      #1;
      calc_comb();
      checks++;
      if (ex_if.PC_Src_E !== exp_src || ex_if.PC_Target_E !== exp_target) begin
        errors++; $display("FAIL rand_redirect[%0d]: got src=%b tgt=%h, required src=%b tgt=%h",
                           n, ex_if.PC_Src_E, ex_if.PC_Target_E, exp_src, exp_target);
      end
      tick();
      checks++;
      if ({ex_if.REG_W_En_M, ex_if.MEM_W_En_M, ex_if.MEM_Control_M, ex_if.Result_Src_Sel_M, ex_if.RD_M,
           ex_if.ALU_Result_M, ex_if.MEM_W_Data_M, ex_if.PC_Plus_4_M} !==
          {m_reg_w, m_mem_w, m_ctl, m_res, m_rd, m_alu, m_wdata, m_pc4}) begin
        errors++; $display("FAIL rand_exmem[%0d]: got alu=%h wd=%h pc4=%h rd=%0d, required alu=%h wd=%h pc4=%h rd=%0d",
                           n, ex_if.ALU_Result_M, ex_if.MEM_W_Data_M, ex_if.PC_Plus_4_M, ex_if.RD_M,
                           m_alu, m_wdata, m_pc4, m_rd);
      end
`ifdef EXEC_PERF_CNT_EN
      checks++;
      if (ex_if.Branch_Cnt !== m_bcnt || ex_if.Taken_Cnt !== m_tcnt) begin
        errors++; $display("FAIL rand_counters[%0d]: got %0d/%0d, required %0d/%0d",
                           n, ex_if.Branch_Cnt, ex_if.Taken_Cnt, m_bcnt, m_tcnt);
      end
`endif
    end
    RST = 0;
    clear_inputs();
  endtask

  initial begin
    RST = 1;
    clear_inputs();
    @(posedge CLK);
    #1;
    test_reset();
    test_add();
    test_forward();
    test_branch();
    test_jalr();
    test_flush();
    test_sra();
`ifdef EXEC_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
